// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state fetch/execute ring with combinational
// strobe decode of state, IR opcode and ALU flags.
module sap1_controller (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       carry,
  output logic       cp,
  output logic       ep,
  output logic       lp,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       su,
  output logic       eu,
  output logic       lo,
  output logic       hlt,
  output logic [2:0] t_state
);

  typedef enum logic [2:0] {
    BOOT = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4   = 3'd4, T5 = 3'd5, T6 = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_JC  = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state, state_next;
  logic   halted;
  logic   halting;

  // Once HLT has been seen in T4 the halt is latched, so later opcode changes cannot release it.
  assign halting = (state == T4) && (halted || opcode == OP_HLT);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      state  <= BOOT;
      halted <= 1'b0;
    end else begin
      state <= state_next;
      if (halting) halted <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    cp = 1'b0; ep = 1'b0; lp = 1'b0; lm  = 1'b0; ce = 1'b0;
    li = 1'b0; ei = 1'b0; la = 1'b0; ea  = 1'b0; lb = 1'b0;
    su = 1'b0; eu = 1'b0; lo = 1'b0; hlt = 1'b0;

    unique case (state)
      BOOT: begin
        ep = 1'b1;
        state_next = T1;
      end
      T1: begin
        lm = 1'b1;
        state_next = T2;
      end
      T2: begin
        cp = 1'b1;
        state_next = T3;
      end
      T3: begin
        ce = 1'b1;
        li = 1'b1;
        state_next = T4;
      end
      T4: begin
        state_next = T5;
        if (halting) begin
          hlt = 1'b1;
          state_next = T4;
        end else begin
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
            OP_OUT: begin ea = 1'b1; lo = 1'b1; end
            OP_JMP: begin ei = 1'b1; lp = 1'b1; end
            OP_JZ:  begin ei = 1'b1; lp = zero; end
            OP_JC:  begin ei = 1'b1; lp = carry; end
            default: ;
          endcase
        end
      end
      T5: begin
        state_next = T6;
        unique case (opcode)
          OP_LDA: begin ce = 1'b1; la = 1'b1; end
          OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        // ep here pre-requests the PC drive, which the PC registers, for the next T1.
        ep = 1'b1;
        state_next = T1;
        unique case (opcode)
          OP_ADD: begin eu = 1'b1; la = 1'b1; end
          OP_SUB: begin su = 1'b1; eu = 1'b1; la = 1'b1; end
          default: ;
        endcase
      end
      default: state_next = BOOT;
    endcase

    if (clr) begin
      cp = 1'b0; ep = 1'b0; lp = 1'b0; lm  = 1'b0; ce = 1'b0;
      li = 1'b0; ei = 1'b0; la = 1'b0; ea  = 1'b0; lb = 1'b0;
      su = 1'b0; eu = 1'b0; lo = 1'b0; hlt = 1'b0;
    end
  end

  assign t_state = clr ? 3'd0 : state;

endmodule
